// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of requester, memory and status signals around the arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_data_i;
  logic [3:0]    m0_sel_i;
  logic          m0_w_r_i;
  logic [DW-1:0] m0_data_o;
  logic          m0_ack_o;
  logic          m0_err_o;
  logic          m1_req_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_data_i;
  logic [3:0]    m1_sel_i;
  logic          m1_w_r_i;
  logic [DW-1:0] m1_data_o;
  logic          m1_ack_o;
  logic          m1_err_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [3:0]    mem_sel_o;
  logic          mem_ena_o;
  logic          mem_w_r_o;
  logic [DW-1:0] mem_data_i;
  logic          mem_valid_i;
  logic          mem_busy_i;
  logic [1:0]    grant_o;
  logic          busy_o;
  modport slave (
    input  m0_req_i, m0_addr_i, m0_data_i, m0_sel_i, m0_w_r_i,
    output m0_data_o, m0_ack_o, m0_err_o,
    input  m1_req_i, m1_addr_i, m1_data_i, m1_sel_i, m1_w_r_i,
    output m1_data_o, m1_ack_o, m1_err_o,
    output mem_addr_o, mem_data_o, mem_sel_o, mem_ena_o, mem_w_r_o,
    input  mem_data_i, mem_valid_i, mem_busy_i,
    output grant_o, busy_o
  );
  modport master (
    output m0_req_i, m0_addr_i, m0_data_i, m0_sel_i, m0_w_r_i,
    input  m0_data_o, m0_ack_o, m0_err_o,
    output m1_req_i, m1_addr_i, m1_data_i, m1_sel_i, m1_w_r_i,
    input  m1_data_o, m1_ack_o, m1_err_o,
    input  mem_addr_o, mem_data_o, mem_sel_o, mem_ena_o, mem_w_r_o,
    output mem_data_i, mem_valid_i, mem_busy_i,
    input  grant_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-master sequencer for the single-port register memory.
// Define MEM_ARB_TIMEOUT_EN to abort an ACCESS with ack+err after TIMEOUT cycles without valid.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
  state_t state, state_n;
  logic ptr, owner, pick, take, done, tmo, rd_done;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdat_n;
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be in 2..255");
  end
  assign pick = (bus.m0_req_i && bus.m1_req_i) ? ptr : bus.m1_req_i;
  assign addr_n = pick ? bus.m1_addr_i : bus.m0_addr_i;
  assign wdat_n = pick ? bus.m1_data_i : bus.m0_data_i;
  assign rd_done = done && bus.mem_valid_i && !bus.mem_w_r_o;
  assign bus.busy_o = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    take = state == IDLE && !bus.mem_busy_i && (bus.m0_req_i || bus.m1_req_i);
    done = state == ACCESS && (bus.mem_valid_i || tmo);
    if (take) state_n = ACCESS;
    else if (done) state_n = RECOVER;
    else if (state == RECOVER) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr <= 1'b0;
      owner <= 1'b0;
      bus.mem_addr_o <= '0;
      bus.mem_data_o <= '0;
      bus.mem_sel_o <= '0;
      bus.mem_w_r_o <= 1'b0;
      bus.mem_ena_o <= 1'b0;
      bus.grant_o <= 2'b00;
      bus.m0_data_o <= '0;
      bus.m1_data_o <= '0;
      bus.m0_ack_o <= 1'b0;
      bus.m1_ack_o <= 1'b0;
    end else begin
      bus.m0_ack_o <= done && !owner;
      bus.m1_ack_o <= done && owner;
      if (take) begin
        owner <= pick;
        bus.mem_addr_o <= addr_n;
        bus.mem_data_o <= wdat_n;
        bus.mem_sel_o <= pick ? bus.m1_sel_i : bus.m0_sel_i;
        bus.mem_w_r_o <= pick ? bus.m1_w_r_i : bus.m0_w_r_i;
        bus.mem_ena_o <= 1'b1;
        bus.grant_o <= pick ? 2'b10 : 2'b01;
      end
      // the finished owner loses priority so continuous requesters alternate
      if (done) begin
        bus.mem_ena_o <= 1'b0;
        ptr <= !owner;
      end
      if (state == RECOVER) bus.grant_o <= 2'b00;
      if (rd_done && !owner) bus.m0_data_o <= bus.mem_data_i;
      if (rd_done && owner) bus.m1_data_o <= bus.mem_data_i;
    end
`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  // valid on the terminal count still completes normally
  assign tmo = state == ACCESS && !bus.mem_valid_i && cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= 8'd0;
      bus.m0_err_o <= 1'b0;
      bus.m1_err_o <= 1'b0;
    end else begin
      cnt <= take ? 8'd0 : state == ACCESS ? cnt + 8'd1 : cnt;
      bus.m0_err_o <= tmo && !owner;
      bus.m1_err_o <= tmo && owner;
    end
`else
  assign tmo = 1'b0;
  assign bus.m0_err_o = 1'b0;
  assign bus.m1_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized directed bench with a behavioural memory and arbitration model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests, fails, fav, gwait, ack_cyc, prev_cyc, cyc, lat, wc;
  bit stall, seeded;
  logic [31:0] a[2], d[2], exp_d[2], ref_mem[16], dev[16];
  logic [3:0] s[2];
  logic w[2];
  function automatic logic [31:0] pattern(int i);
    return 32'h1000_0001 + (32'(i) << 8);
  endfunction
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] sl);
    for (int i = 0; i < 4; i++) if (sl[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // behavioural memory: valid after lat extra enabled cycles, dropped once ena falls
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 16; i++) dev[i] <= pattern(i);
      seeded <= 1'b1;
    end
    if (!bus.mem_ena_o) begin
      bus.mem_valid_i <= 1'b0;
      wc <= 0;
    end else begin
      wc <= wc + 1;
      if (!stall && !bus.mem_valid_i && wc >= lat) begin
        bus.mem_valid_i <= 1'b1;
        if (bus.mem_w_r_o) dev[bus.mem_addr_o[3:0]] <= merge(dev[bus.mem_addr_o[3:0]], bus.mem_data_o, bus.mem_sel_o);
        else bus.mem_data_i <= dev[bus.mem_addr_o[3:0]];
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    bus.m0_addr_i = a[0]; bus.m0_data_i = d[0]; bus.m0_sel_i = s[0]; bus.m0_w_r_i = w[0];
    bus.m1_addr_i = a[1]; bus.m1_data_i = d[1]; bus.m1_sel_i = s[1]; bus.m1_w_r_i = w[1];
  endtask
  task automatic rnd_fields();
    for (int i = 0; i < 2; i++) begin
      a[i] = 32'($urandom_range(0, 15));
      d[i] = $urandom;
      s[i] = 4'($urandom_range(0, 15));
      w[i] = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    fav = 0;
    exp_d[0] = '0;
    exp_d[1] = '0;
  endtask
  task automatic xfer(input logic [1:0] rq, input bit hold);
    int win, n;
    logic [31:0] la, ld;
    logic [3:0] ls;
    logic lw;
    win = (rq == 2'b11) ? fav : (rq[1] ? 1 : 0);
    la = a[win]; ld = d[win]; ls = s[win]; lw = w[win];
    drive();
    bus.m0_req_i = rq[0];
    bus.m1_req_i = rq[1];
    n = 0;
    do begin @(negedge clk); n++; end while (bus.grant_o == 2'b00 && n < 50);
    gwait = n;
    chk("grant", bus.grant_o, win ? 2'b10 : 2'b01);
    chk("ena_on", bus.mem_ena_o, 1);
    chk("busy_on", bus.busy_o, 1);
    chk("mem_addr", bus.mem_addr_o, la);
    chk("mem_w_r", bus.mem_w_r_o, lw);
    if (lw) chk("mem_wdata", {bus.mem_sel_o, bus.mem_data_o}, {ls, ld});
    a[win] = 32'($urandom_range(0, 15)); d[win] = $urandom; w[win] = ~lw;
    drive();
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.m0_ack_o || bus.m1_ack_o) && n < 50);
    ack_cyc = cyc;
    chk("ack", {bus.m1_ack_o, bus.m0_ack_o}, win ? 2'b10 : 2'b01);
    chk("ena_off", bus.mem_ena_o, 0);
    chk("held_addr", bus.mem_addr_o, la);
    if (lw) ref_mem[la[3:0]] = merge(ref_mem[la[3:0]], ld, ls);
    else exp_d[win] = ref_mem[la[3:0]];
    fav = 1 - win;
    chk("m0_data", bus.m0_data_o, exp_d[0]);
    chk("m1_data", bus.m1_data_o, exp_d[1]);
    chk("err", {bus.m1_err_o, bus.m0_err_o}, 0);
    if (!hold) begin bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0; end
    @(negedge clk);
    chk("ack_pulse", {bus.m1_ack_o, bus.m0_ack_o}, 0);
    chk("grant_clr", bus.grant_o, 0);
    chk("busy_clr", bus.busy_o, 0);
  endtask
  initial begin
    int n;
    bit seen;
    tests = 0; fails = 0; fav = 0; stall = 1'b0; lat = 0; cyc = 0; wc = 0; seeded = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = pattern(i);
    exp_d[0] = '0; exp_d[1] = '0;
    for (int i = 0; i < 2; i++) begin a[i] = '0; d[i] = '0; s[i] = 4'hF; w[i] = 1'b0; end
    drive();
    bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0; bus.mem_busy_i = 1'b0;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {bus.mem_ena_o, bus.mem_w_r_o, bus.grant_o, bus.busy_o, bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}, 0);
    chk("rst_mem", {bus.mem_addr_o, bus.mem_data_o}, 0);
    chk("rst_data", {bus.m0_data_o, bus.m1_data_o}, 0);
    rst = 1'b1;
    @(negedge clk);
    // m0 read of address 0
    a[0] = 0; w[0] = 1'b0;
    xfer(2'b01, 1'b0);
    chk("m0_rd0", bus.m0_data_o, 32'h1000_0001);
    // m1 write then read back
    a[1] = 1; d[1] = 32'hCAFE_0002; s[1] = 4'hF; w[1] = 1'b1;
    xfer(2'b10, 1'b0);
    a[1] = 1; w[1] = 1'b0;
    xfer(2'b10, 1'b0);
    chk("m1_rd1", bus.m1_data_o, 32'hCAFE_0002);
    chk("m0_keep", bus.m0_data_o, 32'h1000_0001);
    // both request continuously from reset
    do_reset();
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      rnd_fields();
      xfer(2'b11, k < 3);
      if (k > 0) chk("ack_spacing", 64'(ack_cyc - prev_cyc), 4);
      prev_cyc = ack_cyc;
    end
    // memory busy holds off the grant
    rnd_fields();
    drive();
    bus.mem_busy_i = 1'b1;
    bus.m0_req_i = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      seen |= bus.mem_ena_o || (bus.grant_o != 2'b00);
    end
    chk("busy_hold", seen, 0);
    bus.mem_busy_i = 1'b0;
    xfer(2'b01, 1'b0);
    chk("busy_release", gwait, 1);
    // randomized traffic
    for (int k = 0; k < 25; k++) begin
      lat = $urandom_range(0, 2);
      rnd_fields();
      xfer(2'($urandom_range(1, 3)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    lat = 0;
    // asynchronous reset in the middle of an access
    stall = 1'b1;
    rnd_fields();
    w[0] = 1'b0;
    drive();
    bus.m0_req_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.grant_o == 2'b00 && n < 50);
    chk("abort_grant", bus.grant_o, 2'b01);
    bus.m0_req_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_outs", {bus.mem_ena_o, bus.grant_o, bus.busy_o, bus.m0_ack_o, bus.m1_ack_o}, 0);
    chk("abort_data", {bus.m0_data_o, bus.m1_data_o}, 0);
    @(negedge clk);
    chk("abort_noack", {bus.m0_ack_o, bus.m1_ack_o}, 0);
    rst = 1'b1;
    fav = 0; exp_d[0] = '0; exp_d[1] = '0;
    stall = 1'b0;
    @(negedge clk);
    rnd_fields();
    xfer(2'b10, 1'b0);
    // memory that never answers
    stall = 1'b1;
    rnd_fields();
    w[0] = 1'b0;
    drive();
    bus.m0_req_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.grant_o == 2'b00 && n < 50);
    chk("stall_grant", bus.grant_o, 2'b01);
    bus.m0_req_i = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.m0_ack_o || bus.m1_ack_o) && n < 50);
    chk("tmo_cycles", n, 4);
    chk("tmo_pulse", {bus.m1_err_o, bus.m1_ack_o, bus.m0_err_o, bus.m0_ack_o}, 4'b0011);
    chk("tmo_data", bus.m0_data_o, exp_d[0]);
    fav = 1;
    @(negedge clk);
    chk("tmo_clear", {bus.m0_err_o, bus.m0_ack_o, bus.grant_o}, 0);
    stall = 1'b0;
    rnd_fields();
    xfer(2'b11, 1'b0);
`else
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      seen |= bus.m0_ack_o || bus.m1_ack_o || bus.m0_err_o || !bus.mem_ena_o;
    end
    chk("wait_forever", seen, 0);
    chk("wait_busy", bus.busy_o, 1);
    stall = 1'b0;
    do_reset();
    rnd_fields();
    xfer(2'b11, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port register memory (ena/w_r/valid/busy handshake, word address, byte select).
- Master 0 is instruction fetch; master 1 is the load/store unit.
- Grants round-robin and latches the winning request.
- Drives the memory enable until valid returns, then returns read data and a one-cycle ack to the winning master.

Parameters:
- AW, 32: address width of masters and memory.
- DW, 32: data width.
- TIMEOUT, 16: cycles in ACCESS before abort. Used only with MEM_ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0_req_i  in  1  master 0 request.
- m0_addr_i  in  AW  master 0 address.
- m0_data_i  in  DW  master 0 write data.
- m0_sel_i  in  4  master 0 byte select.
- m0_w_r_i  in  1  master 0 direction: 1 = write, 0 = read.
- m0_data_o  out  DW  master 0 read data.
- m0_ack_o  out  1  master 0 done pulse.
- m0_err_o  out  1  master 0 timeout flag.
- m1_req_i, m1_addr_i, m1_data_i, m1_sel_i, m1_w_r_i, m1_data_o, m1_ack_o, m1_err_o: same as master 0, for master 1.
- mem_addr_o  out  AW  to memory addr_i.
- mem_data_o  out  DW  to memory data_i.
- mem_sel_o  out  4  to memory sel_byte_i.
- mem_ena_o  out  1  to memory ena_i.
- mem_w_r_o  out  1  to memory w_r_i.
- mem_data_i  in  DW  from memory data_o.
- mem_valid_i  in  1  from memory valid_o.
- mem_busy_i  in  1  from memory busy.
- grant_o  out  2  one-hot current owner; 00 when idle.
- busy_o  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE and the priority pointer to master 0.
  - All outputs go to 0: mem_*_o, mX_data_o, mX_ack_o, mX_err_o, grant_o, busy_o.
  - Latched request registers clear to 0.
  - Reset mid-ACCESS aborts the transfer silently: no ack. The memory sees ena fall immediately.
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE:
  - Requests are sampled only here.
  - If mem_busy_i=1 or no req, stay in IDLE.
  - If exactly one req is high, grant it. If both are high, grant the master the pointer favours.
  - On grant: latch addr, data, sel and w_r into mem_*_o registers, set grant_o, go to ACCESS. mem_ena_o=1 from the next cycle.
- ACCESS:
  - mem_ena_o=1; latched fields are held constant.
  - When mem_valid_i=1 is sampled:
    - On a read, copy mem_data_i into the granted mX_data_o.
    - On a write, leave mX_data_o unchanged.
    - Pulse mX_ack_o for exactly one cycle (registered, the cycle after valid is sampled).
    - Clear mem_ena_o at the same edge, move the pointer to favour the other master, go to RECOVER.
- RECOVER:
  - Lasts one cycle with mem_ena_o=0 so the memory deasserts valid.
  - grant_o is cleared, then return to IDLE.
  - Requests are ignored here. A master that still holds req after seeing ack is treated as a new request in IDLE.
- Minimum occupancy: grant edge, ≥1 ACCESS cycle, 1 RECOVER cycle. With a one-cycle memory, back-to-back transfers complete every 4 cycles.
- mX_data_o holds its last value until the next read to that master.
- mX_ack_o is never high for both masters, and never high for 2 consecutive cycles.
- Fairness: with both masters requesting continuously, grants strictly alternate.
- Requester inputs may change after the grant edge without effect.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle.
  - If it reaches TIMEOUT with no valid, go to RECOVER, pulse mX_ack_o and mX_err_o together for one cycle, leave data_o unchanged, and rotate the pointer.
  - If valid arrives on the same cycle as the count hit, valid wins: normal ack, err=0.
- Not defined: no counter is built; mX_err_o is tied to 0; ACCESS waits indefinitely.

Test Plan:
- Reset, then m0 read at addr 0 → mem_ena_o high for ACCESS; m0_data_o=32'h1000_0001; single m0_ack_o pulse; grant_o returns to 00.
- m1 write addr 1 data 32'hCAFE_0002, then m1 read addr 1 → m1_data_o=32'hCAFE_0002; m0 outputs unchanged.
- Both masters hold req for 4 transfers from reset → grant order m0, m1, m0, m1; acks 4 cycles apart.
- mem_busy_i=1 with m0_req_i=1 for 5 cycles → no ena and grant_o=00 throughout; grant on the first cycle busy=0.
- Drop rst during ACCESS → all outputs 0 immediately, no ack; after release a new m1 request is granted (pointer back to m0, m0 idle).
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=4, memory valid forced 0 → m0_ack_o and m0_err_o pulse together after 4 ACCESS cycles, then IDLE; without the macro the block stays in ACCESS.
